// File: rtl/io_port_controller.sv
// Memory-mapped I/O port block: output latch, synchronised/debounced input,
// sticky change flag with optional interrupt, and window decode for read muxing.
module io_port_controller #(
    parameter logic [31:0] IO_BASE         = 32'h1001_0040,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter logic [31:0] OUT_RESET       = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [7:0]  PortIn,
    output logic [31:0] ReadData,
    output logic        IOSelect,
    output logic [31:0] PortOut,
    output logic        ChangeIRQ
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] OFF_PORT_OUT = 2'd0;
    localparam logic [1:0] OFF_PORT_IN  = 2'd1;
    localparam logic [1:0] OFF_STATUS   = 2'd2;
    localparam logic [1:0] OFF_CONTROL  = 2'd3;

    logic [7:0]       sync1;
    logic [7:0]       sync2;
    logic [7:0]       candidate;
    logic [7:0]       stable;
    logic [CNT_W-1:0] count;
    logic             chg;
    logic             ie;
    logic [1:0]       offset;
    logic             wr;
    logic             accept;
    logic [1:0]       unused_addr_lsb;

    // Word-only access: byte offset within a word carries no meaning here.
    assign unused_addr_lsb = Address[1:0];

    assign IOSelect  = (Address[31:4] == IO_BASE[31:4]);
    assign offset    = Address[3:2];
    assign wr        = MemWrite & IOSelect;
    assign ChangeIRQ = chg & ie;

    // A candidate held long enough and differing from the accepted value is taken.
    assign accept = (sync2 == candidate) && (count == CNT_MAX) && (candidate != stable);

    // Input synchroniser and debounce counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1     <= 8'h00;
            sync2     <= 8'h00;
            candidate <= 8'h00;
            stable    <= 8'h00;
            count     <= '0;
        end else begin
            sync1 <= PortIn;
            sync2 <= sync1;
            if (sync2 != candidate) begin
                candidate <= sync2;
                count     <= '0;
            end else if (count < CNT_MAX) begin
                count <= count + CNT_W'(1);
            end else if (accept) begin
                stable <= candidate;
            end
        end
    end

    // Software-visible registers; a new acceptance beats a same-edge W1C.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            PortOut <= OUT_RESET;
            chg     <= 1'b0;
            ie      <= 1'b0;
        end else begin
            if (wr && offset == OFF_PORT_OUT) begin
                PortOut <= WriteData;
            end
            if (wr && offset == OFF_CONTROL) begin
                ie <= WriteData[0];
            end
            if (accept) begin
                chg <= 1'b1;
            end else if (wr && offset == OFF_STATUS && WriteData[0]) begin
                chg <= 1'b0;
            end
        end
    end

    // Load data mux; zero when not a load into this window.
    always_comb begin
        ReadData = 32'h0;
        if (MemRead && IOSelect) begin
            case (offset)
                OFF_PORT_OUT: ReadData = PortOut;
                OFF_PORT_IN:  ReadData = {24'h0, stable};
                OFF_STATUS:   ReadData = {31'h0, chg};
                OFF_CONTROL:  ReadData = {31'h0, ie};
                default:      ReadData = 32'h0;
            endcase
        end
    end

endmodule
